// File: rtl/button_arbiter_pkg.sv
// Shared definitions for the button arbiter: FSM encoding and default sizing.
package button_arbiter_pkg;

   localparam int N_BTN_DEF = 4;
   localparam int IDX_W_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/button_arbiter_if.sv
// Command stream handshake between the arbiter and its downstream consumer.
interface button_arbiter_if #(
   parameter int IDX_W = 2
) ();

   logic             cmd_valid;
   logic [IDX_W-1:0] cmd_id;
   logic             cmd_ready;

   modport master (output cmd_valid, output cmd_id, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_id, output cmd_ready);

endinterface

// File: rtl/button_arbiter_rr_select.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo N_BTN.
module rr_select #(
   parameter int N_BTN = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_BTN-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan from farthest to nearest so the nearest hit after last_i wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = N_BTN; k >= 1; k--) begin
         int pos;
         pos = int'(last_i) + k;
         if (pos >= N_BTN) pos = pos - N_BTN;
         if (req_i[pos]) begin
            found_o = 1'b1;
            idx_o   = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/button_arbiter.sv
// Latches button presses and serialises them as round-robin commands over a valid/ready stream.
module button_arbiter
   import button_arbiter_pkg::*;
#(
   parameter int N_BTN = N_BTN_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic                clock_i,
   input  logic                reset_ni,
   input  logic [N_BTN-1:0]    rising_i,
   input  logic [N_BTN-1:0]    enable_i,
   button_arbiter_if.master    cmd,
   output logic [N_BTN-1:0]    pending_o,
   output logic                overflow_o,
   output logic                busy_o
);

   state_e             state_q;
   logic               valid_q;
   logic [IDX_W-1:0]   id_q;
   logic [IDX_W-1:0]   last_q;
   logic [N_BTN-1:0]   pend_q;
   logic [N_BTN-1:0]   pend_d;
   logic               ovf_q;
   logic               ovf_d;

   logic [N_BTN-1:0]   eligible;
   logic [N_BTN-1:0]   press;
   logic [N_BTN-1:0]   offer_vec;
   logic [N_BTN-1:0]   accept_vec;
   logic               accept;
   logic               found;
   logic [IDX_W-1:0]   sel_idx;

   assign eligible   = pend_q & enable_i;
   assign press      = rising_i & enable_i;
   assign accept     = (state_q == ST_OFFER) && cmd.cmd_ready;
   assign offer_vec  = (state_q == ST_OFFER) ? (N_BTN'(1) << id_q) : '0;
   assign accept_vec = accept ? offer_vec : '0;

   // The offered channel keeps its request through an enable drop so the offer can complete.
   assign pend_d = (pend_q & ~accept_vec & (enable_i | offer_vec)) | press;
   assign ovf_d  = |(press & pend_q & ~accept_vec);

   rr_select #(
      .N_BTN (N_BTN),
      .IDX_W (IDX_W)
   ) u_rr_select (
      .req_i   (eligible),
      .last_i  (last_q),
      .found_o (found),
      .idx_o   (sel_idx)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         id_q    <= '0;
         last_q  <= IDX_W'(N_BTN - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (found) begin
                  id_q    <= sel_idx;
                  valid_q <= 1'b1;
                  state_q <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (cmd.cmd_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= id_q;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd.cmd_valid = valid_q;
   assign cmd.cmd_id    = id_q;
   assign pending_o     = pend_q;
   assign overflow_o    = ovf_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_button_arbiter.sv
// Self-checking bench for button_arbiter: directed vector table, reset corner case, random vs model.
module tb_button_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rising = '0;
   logic [3:0] enable = 4'hF;
   logic [3:0] pending;
   logic       overflow;
   logic       busy;

   button_arbiter_if #(.IDX_W(2)) cmd_if ();

   button_arbiter #(
      .N_BTN (4),
      .IDX_W (2)
   ) dut (
      .clock_i    (clk),
      .reset_ni   (rst_n),
      .rising_i   (rising),
      .enable_i   (enable),
      .cmd        (cmd_if.master),
      .pending_o  (pending),
      .overflow_o (overflow),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] rise;
      logic [3:0] en;
      logic       rdy;
      logic       v;
      logic [1:0] id;
      logic [3:0] pend;
      logic       ovf;
      logic       bsy;
   } vec_t;

   vec_t tbl [38];

   // reference model state
   bit [3:0] m_p;
   int       m_off;
   int       m_last;
   int       m_id;
   bit       m_gap;
   bit       m_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rising = '0;
      enable = 4'hF;
      cmd_if.cmd_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      m_p = '0; m_off = -1; m_last = 3; m_id = 0; m_gap = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic [3:0] en, input logic rdy);
      bit [3:0] np;
      bit       ovf;
      bit       acc;
      acc = (m_off >= 0) && rdy;
      ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit pr;
         pr = r[i] && en[i];
         if (acc && i == m_off) np[i] = pr;
         else if (!en[i] && i != m_off) np[i] = 1'b0;
         else begin
            if (pr && m_p[i]) ovf = 1'b1;
            np[i] = m_p[i] || pr;
         end
      end
      if (m_off >= 0) begin
         if (rdy) begin
            m_last = m_off;
            m_off = -1;
            m_gap = 1'b1;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (m_off < 0 && m_p[c] && en[c]) begin
               m_off = c;
               m_id = c;
            end
         end
      end
      m_p = np;
      m_ovf = ovf;
   endtask

   initial begin
      int got;
      // rise, en, rdy | valid, id, pending, overflow, busy
      tbl[0]  = '{4'b1011, 4'hF, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0, 1'b0};
      tbl[1]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd0, 4'b1011, 1'b0, 1'b1};
      tbl[2]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd0, 4'b1011, 1'b0, 1'b1};
      tbl[3]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b1010, 1'b0, 1'b1};
      tbl[4]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b1010, 1'b0, 1'b0};
      tbl[5]  = '{4'b0000, 4'hF, 1'b1, 1'b1, 2'd1, 4'b1010, 1'b0, 1'b1};
      tbl[6]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd1, 4'b1000, 1'b0, 1'b1};
      tbl[7]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd1, 4'b1000, 1'b0, 1'b0};
      tbl[8]  = '{4'b0000, 4'hF, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1};
      tbl[9]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b1};
      tbl[10] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0};
      tbl[11] = '{4'b0100, 4'hF, 1'b1, 1'b0, 2'd3, 4'b0100, 1'b0, 1'b0};
      tbl[12] = '{4'b0000, 4'hF, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1};
      tbl[13] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b1};
      tbl[14] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
      tbl[15] = '{4'b0001, 4'hF, 1'b0, 1'b0, 2'd2, 4'b0001, 1'b0, 1'b0};
      tbl[16] = '{4'b0010, 4'hF, 1'b0, 1'b1, 2'd0, 4'b0011, 1'b0, 1'b1};
      tbl[17] = '{4'b0010, 4'hF, 1'b0, 1'b1, 2'd0, 4'b0011, 1'b1, 1'b1};
      tbl[18] = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd0, 4'b0011, 1'b0, 1'b1};
      tbl[19] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b1};
      tbl[20] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0};
      tbl[21] = '{4'b0000, 4'hF, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1};
      tbl[22] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b1};
      tbl[23] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0};
      tbl[24] = '{4'b0100, 4'hF, 1'b0, 1'b0, 2'd1, 4'b0100, 1'b0, 1'b0};
      tbl[25] = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1};
      tbl[26] = '{4'b0100, 4'hF, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b1};
      tbl[27] = '{4'b0000, 4'hF, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0};
      tbl[28] = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1};
      tbl[29] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b1};
      tbl[30] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
      tbl[31] = '{4'b0001, 4'hE, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
      tbl[32] = '{4'b1000, 4'hF, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b0, 1'b0};
      tbl[33] = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1};
      tbl[34] = '{4'b0000, 4'h7, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1};
      tbl[35] = '{4'b0000, 4'h7, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1};
      tbl[36] = '{4'b0000, 4'h7, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b1};
      tbl[37] = '{4'b0000, 4'hF, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0};

      cmd_if.cmd_ready = 1'b0;
      #2;
      chk("reset_valid", 32'(cmd_if.cmd_valid), 32'd0);
      chk("reset_pending", 32'(pending), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_id", 32'(cmd_if.cmd_id), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      do_reset();

      for (int i = 0; i < 38; i++) begin
         rising = tbl[i].rise;
         enable = tbl[i].en;
         cmd_if.cmd_ready = tbl[i].rdy;
         step();
         chk($sformatf("tbl%0d_valid", i), 32'(cmd_if.cmd_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_id", i), 32'(cmd_if.cmd_id), 32'(tbl[i].id));
         chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
         chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      end

      // asynchronous reset in the middle of an offer
      rising = 4'b0110;
      enable = 4'hF;
      cmd_if.cmd_ready = 1'b0;
      step();
      rising = '0;
      step();
      chk("pre_reset_valid", 32'(cmd_if.cmd_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midoffer_valid", 32'(cmd_if.cmd_valid), 32'd0);
      chk("midoffer_pending", 32'(pending), 32'd0);
      chk("midoffer_busy", 32'(busy), 32'd0);
      step();
      rst_n = 1'b1;
      rising = 4'b1111;
      step();
      rising = '0;
      got = 0;
      for (int c = 0; c < 5 && got == 0; c++) begin
         step();
         if (cmd_if.cmd_valid) got = 1;
      end
      chk("post_reset_offer_seen", 32'(got), 32'd1);
      chk("post_reset_first_id", 32'(cmd_if.cmd_id), 32'd0);

      // randomized traffic against the reference model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         logic [3:0] r;
         logic [3:0] e;
         logic       rd;
         r  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         e  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         rd = ($urandom_range(0, 2) == 0);
         rising = r;
         enable = e;
         cmd_if.cmd_ready = rd;
         model_step(r, e, rd);
         step();
         chk("rnd_valid", 32'(cmd_if.cmd_valid), 32'(m_off >= 0));
         chk("rnd_id", 32'(cmd_if.cmd_id), 32'(m_id));
         chk("rnd_pending", 32'(pending), 32'(m_p));
         chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
         chk("rnd_busy", 32'(busy), 32'((m_off >= 0) || m_gap));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
